clock_timekeeper: RTL and testbench

Parametrised time-of-day core for the next-generation VGA clock project. Divides the system clock to a 1 Hz tick, keeps hours/minutes/seconds, and takes three raw push-buttons with synchronisation, debounce and auto-repeat. It presents BCD time in 12 h or 24 h format to the VGA renderer, which replaces the fixed-function counting of the first-generation clock design.

---
 rtl/clock_timekeeper.sv | 162 ++++++++++++++++
 tb/tb_clock_timekeeper.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_timekeeper.sv
`timescale 1ns/1ps
// Time-of-day core: 1 Hz prescaler, HH:MM:SS keeping, debounced auto-repeat
// adjust buttons and 12 h / 24 h BCD hour display.
module clock_timekeeper #(
    parameter int unsigned CLK_HZ          = 31500000,
    parameter int unsigned DEBOUNCE_CYCLES = 65536,
    parameter int unsigned REPEAT_CYCLES   = 7875000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       adj_hrs,
    input  logic       adj_min,
    input  logic       adj_sec,
    input  logic       mode_12h,
    output logic [7:0] hrs_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       pm,
    output logic       sec_tick
);

    localparam int unsigned PS_W = $clog2(CLK_HZ);
    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned RP_W = $clog2(REPEAT_CYCLES);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_HZ - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);

    logic [PS_W-1:0]       presc_q, presc_d;
    logic                  tick_q, tick_d;
    logic [2:0]            raw;
    logic [2:0]            sync1_q, sync2_q;
    logic [2:0]            deb_q, deb_d, deb_prev_q;
    logic [2:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [2:0][RP_W-1:0]  rpt_q, rpt_d;
    logic [2:0]            evt_c;
    logic [4:0]            hour_q, hour_d;
    logic [7:0]            min_q, min_d, sec_q, sec_d;
    logic [4:0]            hour_disp;

    assign raw = {adj_hrs, adj_min, adj_sec};

    // Two-digit BCD increment wrapping 59 -> 00.
    function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
        if (v == 8'h59) begin
            return 8'h00;
        end else if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    function automatic logic [4:0] hour_inc(input logic [4:0] h);
        return (h == 5'd23) ? 5'd0 : h + 5'd1;
    endfunction

    always_comb begin
        presc_d = (presc_q == PS_LAST) ? '0 : presc_q + PS_W'(1);
        tick_d  = (presc_d == PS_LAST);
    end

    // Debounce and auto-repeat; the rise cycle itself does not advance the repeat count.
    always_comb begin
        db_cnt_d = '0;
        deb_d    = deb_q;
        rpt_d    = '0;
        evt_c    = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
            if (deb_q[i] && deb_prev_q[i]) begin
                if (rpt_q[i] == RP_LAST) begin
                    evt_c[i] = 1'b1;
                end else begin
                    rpt_d[i] = rpt_q[i] + RP_W'(1);
                end
            end
            if (deb_q[i] && !deb_prev_q[i]) begin
                evt_c[i] = 1'b1;
            end
        end
    end

    // Adjust events take priority; a coincident tick increment is dropped.
    always_comb begin
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        if (|evt_c) begin
            if (evt_c[0]) sec_d  = bcd_inc60(sec_q);
            if (evt_c[1]) min_d  = bcd_inc60(min_q);
            if (evt_c[2]) hour_d = hour_inc(hour_q);
        end else if (tick_q) begin
            sec_d = bcd_inc60(sec_q);
            if (sec_q == 8'h59) begin
                min_d = bcd_inc60(min_q);
                if (min_q == 8'h59) begin
                    hour_d = hour_inc(hour_q);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q    <= '0;
            tick_q     <= 1'b0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            db_cnt_q   <= '0;
            rpt_q      <= '0;
            hour_q     <= '0;
            min_q      <= '0;
            sec_q      <= '0;
        end else begin
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            db_cnt_q   <= db_cnt_d;
            rpt_q      <= rpt_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
        end
    end

    // 12 h mode shows 0 as 12 and folds 13..23 onto 1..11.
    always_comb begin
        hour_disp = hour_q;
        if (mode_12h) begin
            if (hour_q == 5'd0) begin
                hour_disp = 5'd12;
            end else if (hour_q > 5'd12) begin
                hour_disp = hour_q - 5'd12;
            end
        end
        if (hour_disp >= 5'd20) begin
            hrs_bcd = {4'd2, 4'(hour_disp - 5'd20)};
        end else if (hour_disp >= 5'd10) begin
            hrs_bcd = {4'd1, 4'(hour_disp - 5'd10)};
        end else begin
            hrs_bcd = {4'd0, 4'(hour_disp)};
        end
    end

    assign pm       = (hour_q >= 5'd12);
    assign min_bcd  = min_q;
    assign sec_bcd  = sec_q;
    assign sec_tick = tick_q;

endmodule

// File: tb/tb_clock_timekeeper.sv
`timescale 1ns/1ps
// Directed bench for clock_timekeeper with CLK_HZ=4, DEBOUNCE_CYCLES=3, REPEAT_CYCLES=8.
module tb_clock_timekeeper;

    localparam int unsigned CLK_HZ = 4;
    localparam int unsigned DB     = 3;
    localparam int unsigned RP     = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       adj_hrs = 1'b0, adj_min = 1'b0, adj_sec = 1'b0, mode_12h = 1'b0;
    logic [7:0] hrs_bcd, min_bcd, sec_bcd;
    logic       pm, sec_tick;

    int edge_n   = -1;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         hour;
        logic       mode;
        logic [7:0] bcd;
        logic       pm;
    } disp_vec_t;

    disp_vec_t vt[14];

    clock_timekeeper #(
        .CLK_HZ(CLK_HZ),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_CYCLES(RP)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .adj_hrs(adj_hrs),
        .adj_min(adj_min),
        .adj_sec(adj_sec),
        .mode_12h(mode_12h),
        .hrs_bcd(hrs_bcd),
        .min_bcd(min_bcd),
        .sec_bcd(sec_bcd),
        .pm(pm),
        .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    // Edge index since reset release: the first rising edge after release is edge 0.
    always @(posedge clk) edge_n <= reset_n ? edge_n + 1 : -1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Park at the falling edge after rising edge n.
    task automatic to_edge(input int n);
        int guard = 0;
        while (edge_n < n && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
        if (edge_n != n) begin
            checks++;
            failures++;
            $display("FAIL to_edge: at=%0d want=%0d", edge_n, n);
        end
    endtask

    task automatic do_reset(input logic mode);
        mode_12h = mode;
        reset_n  = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // min+hrs events at 7+8k cover ticks at 7 mod 8, sec events at 11+8k cover 3 mod 8.
    task automatic preload(input logic with_hrs, input int sec_events);
        do_reset(1'b0);
        to_edge(1);
        adj_min = 1'b1;
        adj_hrs = with_hrs;
        to_edge(5);
        adj_sec = 1'b1;
        for (int e = 6; e <= 471; e++) begin
            to_edge(e);
            if (e == 183) adj_hrs = 1'b0;
            if (e == 11 + 8 * (sec_events - 1)) adj_sec = 1'b0;
            if (e == 471) adj_min = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    initial begin
        int ticks;
        int ev;

        vt[0]  = '{0,  1'b1, 8'h12, 1'b0};
        vt[1]  = '{0,  1'b0, 8'h00, 1'b0};
        vt[2]  = '{1,  1'b1, 8'h01, 1'b0};
        vt[3]  = '{9,  1'b0, 8'h09, 1'b0};
        vt[4]  = '{10, 1'b0, 8'h10, 1'b0};
        vt[5]  = '{11, 1'b1, 8'h11, 1'b0};
        vt[6]  = '{12, 1'b1, 8'h12, 1'b1};
        vt[7]  = '{12, 1'b0, 8'h12, 1'b1};
        vt[8]  = '{13, 1'b1, 8'h01, 1'b1};
        vt[9]  = '{13, 1'b0, 8'h13, 1'b1};
        vt[10] = '{19, 1'b0, 8'h19, 1'b1};
        vt[11] = '{20, 1'b1, 8'h08, 1'b1};
        vt[12] = '{23, 1'b0, 8'h23, 1'b1};
        vt[13] = '{23, 1'b1, 8'h11, 1'b1};

        // Reset values in both display modes
        do_reset(1'b1);
        #1;
        check("rst_hrs_12h", hrs_bcd, 8'h12);
        check("rst_min", min_bcd, 8'h00);
        check("rst_sec", sec_bcd, 8'h00);
        check("rst_pm", pm, 1'b0);
        check("rst_tick", sec_tick, 1'b0);
        mode_12h = 1'b0;
        #1;
        check("rst_hrs_24h", hrs_bcd, 8'h00);

        // First tick timing, then tick count and elapsed time over 4000 cycles
        do_reset(1'b0);
        to_edge(1);
        check("tick_e1", sec_tick, 1'b0);
        to_edge(2);
        check("tick_e2", sec_tick, 1'b1);
        check("sec_e2", sec_bcd, 8'h00);
        to_edge(3);
        check("tick_e3", sec_tick, 1'b0);
        check("sec_e3", sec_bcd, 8'h01);
        ticks = 1;
        for (int e = 3; e < 4000; e++) begin
            to_edge(e);
            if (sec_tick) ticks++;
        end
        check("tick_count", ticks, 1000);
        check("run_hrs", hrs_bcd, 8'h00);
        check("run_min", min_bcd, 8'h16);
        check("run_sec", sec_bcd, 8'h40);

        // Hour display table while adj_hrs auto-repeats from hour 0
        do_reset(1'b0);
        adj_hrs = 1'b1;
        for (int i = 0; i < 14; i++) begin
            ev = (vt[i].hour == 0) ? 4 : 5 + 8 * (vt[i].hour - 1);
            to_edge(ev);
            mode_12h = vt[i].mode;
            #1;
            check($sformatf("disp_h%0d_m%0d", vt[i].hour, vt[i].mode), hrs_bcd, vt[i].bcd);
            check($sformatf("pm_h%0d", vt[i].hour), pm, vt[i].pm);
        end
        adj_hrs  = 1'b0;
        mode_12h = 1'b0;

        // Glitches of 1 and 2 cycles, then a 4-cycle hold
        do_reset(1'b0);
        adj_min = 1'b1;
        to_edge(0);
        adj_min = 1'b0;
        to_edge(10);
        adj_min = 1'b1;
        to_edge(12);
        adj_min = 1'b0;
        to_edge(30);
        check("glitch_min", min_bcd, 8'h00);
        adj_min = 1'b1;
        to_edge(34);
        adj_min = 1'b0;
        to_edge(35);
        check("hold4_before", min_bcd, 8'h00);
        to_edge(36);
        check("hold4_after", min_bcd, 8'h01);
        check("hold4_hrs", hrs_bcd, 8'h00);

        // 20-cycle hold gives three events; a re-press needs a fresh debounce
        do_reset(1'b0);
        adj_hrs = 1'b1;
        to_edge(4);
        check("rep_e4", hrs_bcd, 8'h00);
        to_edge(5);
        check("rep_e5", hrs_bcd, 8'h01);
        to_edge(12);
        check("rep_e12", hrs_bcd, 8'h01);
        to_edge(13);
        check("rep_e13", hrs_bcd, 8'h02);
        to_edge(19);
        adj_hrs = 1'b0;
        to_edge(20);
        check("rep_e20", hrs_bcd, 8'h02);
        to_edge(21);
        check("rep_e21", hrs_bcd, 8'h03);
        to_edge(29);
        check("rep_e29", hrs_bcd, 8'h03);
        adj_hrs = 1'b1;
        to_edge(34);
        check("repress_e34", hrs_bcd, 8'h03);
        to_edge(35);
        check("repress_e35", hrs_bcd, 8'h04);
        adj_hrs = 1'b0;

        // 00:59:59 -> 01:00:00
        preload(1'b0, 58);
        check("pre1_hrs", hrs_bcd, 8'h00);
        check("pre1_min", min_bcd, 8'h59);
        check("pre1_sec", sec_bcd, 8'h59);
        to_edge(474);
        check("pre1_tick", sec_tick, 1'b1);
        to_edge(475);
        check("carry_hrs", hrs_bcd, 8'h01);
        check("carry_min", min_bcd, 8'h00);
        check("carry_sec", sec_bcd, 8'h00);

        // 23:59:59 -> 00:00:00 with pm falling
        preload(1'b1, 58);
        check("pre2_hrs", hrs_bcd, 8'h23);
        check("pre2_min", min_bcd, 8'h59);
        check("pre2_sec", sec_bcd, 8'h59);
        check("pre2_pm", pm, 1'b1);
        mode_12h = 1'b1;
        #1;
        check("pre2_hrs12", hrs_bcd, 8'h11);
        mode_12h = 1'b0;
        to_edge(474);
        check("pre2_tick", sec_tick, 1'b1);
        to_edge(475);
        check("wrap_hrs", hrs_bcd, 8'h00);
        check("wrap_min", min_bcd, 8'h00);
        check("wrap_sec", sec_bcd, 8'h00);
        check("wrap_pm", pm, 1'b0);

        // Seconds adjust coincident with the tick at :59 drops the carry
        preload(1'b0, 59);
        check("pre3_sec", sec_bcd, 8'h59);
        to_edge(474);
        check("coin_tick", sec_tick, 1'b1);
        to_edge(475);
        adj_sec = 1'b0;
        check("coin_sec", sec_bcd, 8'h00);
        check("coin_min", min_bcd, 8'h59);
        check("coin_hrs", hrs_bcd, 8'h00);
        adj_min = 1'b1;
        to_edge(480);
        check("mininc_before", min_bcd, 8'h59);
        to_edge(481);
        adj_min = 1'b0;
        check("mininc_min", min_bcd, 8'h00);
        check("mininc_hrs", hrs_bcd, 8'h00);

        // Reset mid-hold clears immediately; held button needs a full debounce after release
        do_reset(1'b0);
        adj_hrs = 1'b1;
        to_edge(13);
        check("mid_hrs", hrs_bcd, 8'h02);
        check("mid_sec", sec_bcd, 8'h03);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_hrs", hrs_bcd, 8'h00);
        check("async_min", min_bcd, 8'h00);
        check("async_sec", sec_bcd, 8'h00);
        check("async_pm", pm, 1'b0);
        check("async_tick", sec_tick, 1'b0);
        mode_12h = 1'b1;
        #1;
        check("async_hrs12", hrs_bcd, 8'h12);
        mode_12h = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        to_edge(4);
        check("post_rst_e4", hrs_bcd, 8'h00);
        to_edge(5);
        check("post_rst_e5", hrs_bcd, 8'h01);
        adj_hrs = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
